// File: rtl/fp_norm_round_seq.sv
// Multi-cycle normalise-and-round stage for the floating-point adder.
// Takes a raw sum (carry/hidden/fraction/G/R/S) and returns a packed,
// round-to-nearest-even result with overflow/underflow/zero/inexact flags
// over a valid/ready handshake, one operand in flight at a time.
module fp_norm_round_seq #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  localparam int SIG_W = FRAC_W + 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [SIG_W-1:0]  in_sig,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [FRAC_W-1:0] out_frac,
  output logic              out_overflow,
  output logic              out_underflow,
  output logic              out_zero,
  output logic              out_inexact
);

  typedef enum logic [2:0] {IDLE, CHECK, SHIFT, ROUND, DONE} state_t;

  state_t             state_q, state_d;
  logic               sign_q;
  logic [EXP_W-1:0]   exp_q;
  logic [SIG_W-1:0]   sig_q;
  logic               ovf_q, unf_q, zero_q, inex_q;

  logic [EXP_W-1:0]   exp_inc, exp_dec;
  logic [SIG_W-1:0]   sig_rsh, sig_lsh;
  logic [FRAC_W-1:0]  frac;
  logic               guard, rnd, sticky, round_up;
  logic [FRAC_W:0]    frac_sum;

  assign exp_inc  = exp_q + EXP_W'(1);
  assign exp_dec  = exp_q - EXP_W'(1);
  // Right shift folds the bits falling off R into the sticky bit.
  assign sig_rsh  = {1'b0, sig_q[SIG_W-1:2], sig_q[1] | sig_q[0]};
  assign sig_lsh  = {sig_q[SIG_W-2:0], 1'b0};

  assign frac     = sig_q[SIG_W-3:3];
  assign guard    = sig_q[2];
  assign rnd      = sig_q[1];
  assign sticky   = sig_q[0];
  assign round_up = guard & (rnd | sticky | frac[0]);
  assign frac_sum = {1'b0, frac} + (FRAC_W+1)'(round_up);

  // in_ready is gated by rst_n so it reads 0 while reset is held.
  assign in_ready      = rst_n && (state_q == IDLE);
  assign out_valid     = (state_q == DONE);
  assign out_sign      = sign_q;
  assign out_exp       = exp_q;
  assign out_frac      = frac;
  assign out_overflow  = ovf_q;
  assign out_underflow = unf_q;
  assign out_zero      = zero_q;
  assign out_inexact   = inex_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state selection; CHECK applies its rules in priority order.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (in_valid && in_ready) state_d = CHECK;
      CHECK: begin
        if (exp_q == '1 || sig_q == '0)          state_d = DONE;
        else if (sig_q[SIG_W-1])                 state_d = (exp_inc == '1) ? DONE : ROUND;
        else if (sig_q[SIG_W-2] || exp_q <= EXP_W'(1)) state_d = ROUND;
        else                                     state_d = SHIFT;
      end
      SHIFT: if (sig_lsh[SIG_W-2] || exp_dec == EXP_W'(1)) state_d = ROUND;
      ROUND: state_d = DONE;
      DONE:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Working datapath: capture, classify, normalise, round; holds in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q <= 1'b0;
      exp_q  <= '0;
      sig_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      zero_q <= 1'b0;
      inex_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid && in_ready) begin
          sign_q <= in_sign;
          exp_q  <= in_exp;
          sig_q  <= in_sig;
          ovf_q  <= 1'b0;
          unf_q  <= 1'b0;
          zero_q <= 1'b0;
          inex_q <= 1'b0;
        end
        CHECK: if (exp_q != '1) begin
          if (sig_q == '0) begin
            zero_q <= 1'b1;
            exp_q  <= '0;
          end else if (sig_q[SIG_W-1]) begin
            exp_q <= exp_inc;
            if (exp_inc == '1) begin
              ovf_q  <= 1'b1;
              inex_q <= 1'b1;
              sig_q  <= '0;
            end else begin
              sig_q <= sig_rsh;
            end
          end else if (!sig_q[SIG_W-2] && exp_q <= EXP_W'(1)) begin
            unf_q <= 1'b1;
            exp_q <= '0;
          end
        end
        SHIFT: begin
          sig_q <= sig_lsh;
          // Reaching the hidden bit wins over reaching the minimum exponent.
          if (!sig_lsh[SIG_W-2] && exp_dec == EXP_W'(1)) begin
            unf_q <= 1'b1;
            exp_q <= '0;
          end else begin
            exp_q <= exp_dec;
          end
        end
        ROUND: begin
          inex_q <= guard | rnd | sticky;
          sig_q[SIG_W-3:3] <= frac_sum[FRAC_W-1:0];
          // Fraction wrap bumps the exponent; for a denormal this lands on 1.
          if (frac_sum[FRAC_W]) begin
            exp_q <= exp_inc;
            if (exp_inc == '1) ovf_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_norm_round_seq.sv
// Randomised self-checking bench for fp_norm_round_seq against an
// integer-arithmetic reference model of the normalise/round rules.
module tb_fp_norm_round_seq;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int SIG_W  = FRAC_W + 5;
  localparam int unsigned FMASK = 32'h007F_FFFF;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_sign = 1'b0;
  logic [EXP_W-1:0]  in_exp = '0;
  logic [SIG_W-1:0]  in_sig = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_sign;
  logic [EXP_W-1:0]  out_exp;
  logic [FRAC_W-1:0] out_frac;
  logic              out_overflow, out_underflow, out_zero, out_inexact;

  fp_norm_round_seq #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_sig(in_sig),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_frac(out_frac),
    .out_overflow(out_overflow), .out_underflow(out_underflow),
    .out_zero(out_zero), .out_inexact(out_inexact)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  typedef struct {
    bit          s;
    int unsigned e;
    int unsigned f;
    bit          ovf, unf, zero, inex;
    int unsigned lat;
  } res_t;

  // Reference: value-level normalise then RNE on the 3 low bits.
  function automatic res_t model(bit s, int unsigned e, int unsigned m);
    res_t r;
    int unsigned msb, k, sh, rem, kept, frac;
    bit up;
    r.s = s; r.e = 0; r.f = 0;
    r.ovf = 0; r.unf = 0; r.zero = 0; r.inex = 0; r.lat = 3;
    if (e == 255) begin
      r.e = 255; r.f = (m >> 3) & FMASK; r.lat = 2;
      return r;
    end
    if (m == 0) begin
      r.zero = 1; r.lat = 2;
      return r;
    end
    if (m >= (1 << 27)) begin
      m = (m >> 1) | (m & 1);
      e = e + 1;
      if (e == 255) begin
        r.e = 255; r.ovf = 1; r.inex = 1; r.lat = 2;
        return r;
      end
    end else if (m < (1 << 26)) begin
      msb = 0;
      for (int i = 0; i < 27; i++) if (((m >> i) & 1) != 0) msb = i;
      k = 26 - msb;
      if (e > k) begin
        m = m << k; e = e - k; r.lat = 3 + k;
      end else begin
        sh = (e >= 2) ? e - 1 : 0;
        m = m << sh; e = 0; r.unf = 1; r.lat = 3 + sh;
      end
    end
    rem  = m & 7;
    kept = m >> 3;
    frac = kept & FMASK;
    up   = (rem > 4) || (rem == 4 && (kept % 2) == 1);
    r.inex = (rem != 0);
    frac = frac + up;
    if (frac == (1 << 23)) begin
      frac = 0;
      e = e + 1;
      if (e == 255) r.ovf = 1;
    end
    r.e = e; r.f = frac;
    return r;
  endfunction

  task automatic check_outputs(input string tag, input res_t r);
    check({tag, ".sign"}, out_sign, r.s);
    check({tag, ".exp"}, out_exp, r.e);
    check({tag, ".frac"}, out_frac, r.f);
    check({tag, ".flags"}, {out_overflow, out_underflow, out_zero, out_inexact},
          {r.ovf, r.unf, r.zero, r.inex});
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_op(input string tag, input bit s, input int unsigned e,
                        input int unsigned m, input int hold);
    res_t r;
    int unsigned lat;
    r = model(s, e, m);
    @(negedge clk);
    check({tag, ".in_ready_idle"}, in_ready, 1'b1);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e[EXP_W-1:0];
    in_sig   = m[SIG_W-1:0];
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sig   = '0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      check({tag, ".timeout"}, 1'b0, 1'b1);
      pulse_reset();
      return;
    end
    check({tag, ".latency"}, lat, r.lat);
    check_outputs(tag, r);
    check({tag, ".in_ready_busy"}, in_ready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, out_valid, 1'b1);
      check({tag, ".hold_in_ready"}, in_ready, 1'b0);
      check_outputs({tag, ".hold"}, r);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".valid_drop"}, out_valid, 1'b0);
    check({tag, ".ready_back"}, in_ready, 1'b1);
  endtask

  initial begin
    int unsigned e, m;
    bit s;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready", in_ready, 1'b0);
    check("rst.out_valid", out_valid, 1'b0);
    check("rst.out_exp", out_exp, 0);
    check("rst.out_frac", out_frac, 0);
    check("rst.flags", {out_overflow, out_underflow, out_zero, out_inexact}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases.
    run_op("carry",     1'b0, 32'h80, 32'h8000000, 0);
    run_op("cancel",    1'b1, 32'h85, 32'h0200000, 0);
    run_op("round_up",  1'b0, 32'h7F, 32'h7FFFFFC, 0);
    run_op("tie_even",  1'b0, 32'h90, 32'h4000004, 0);
    run_op("overflow",  1'b1, 32'hFE, 32'h8000000, 0);
    run_op("underflow", 1'b0, 32'h03, 32'h0100000, 0);
    run_op("zero",      1'b0, 32'h42, 32'h0000000, 0);
    run_op("nan",       1'b0, 32'hFF, 32'h4000008, 0);
    run_op("denorm_in", 1'b0, 32'h01, 32'h0000FFF, 0);
    run_op("denorm_rnd",1'b0, 32'h00, 32'h3FFFFFC, 0);
    run_op("round_ovf", 1'b0, 32'hFE, 32'h7FFFFFC, 0);
    run_op("backpress", 1'b1, 32'h40, 32'h5555557, 5);

    // Reset while normalising: operand is dropped, next one is clean.
    @(negedge clk);
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'h85; in_sig = 28'h0200000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.out_valid", out_valid, 1'b0);
    check("midrst.in_ready", in_ready, 1'b0);
    check("midrst.out_exp", out_exp, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst.ready_after", in_ready, 1'b1);
    run_op("post_rst",  1'b0, 32'h85, 32'h0200000, 0);

    // Randomised operands biased toward boundary exponents and patterns.
    for (int n = 0; n < 200; n++) begin
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       e = 0;
        1:       e = 1;
        2:       e = $urandom_range(2, 4);
        3:       e = $urandom_range(32'hFC, 32'hFF);
        default: e = $urandom_range(0, 255);
      endcase
      case ($urandom_range(0, 9))
        0:       m = 0;
        1:       m = 32'h7FFFFF8 | ($urandom & 7);
        2:       m = 32'h8000000 | ($urandom & 32'h7FFFFFF);
        3:       m = 32'h4000000 | ($urandom & 32'h3FFFFFF);
        default: m = ($urandom & 32'hFFFFFFF) >> $urandom_range(0, 27);
      endcase
      run_op("rand", s, e, m, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
